// File: rtl/spi_master_m3.sv
// Mode-3 SPI master: MSB-first bytes from a valid/ready stream, CS held low across
// multi-byte transactions until a byte flagged last completes.
module spi_master_m3 #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       com_clk,
  output logic       CS,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT_NEXT, HOLD, GAP} state_t;

  localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_END   = 16'(CS_IDLE - 1);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh, sh_nxt, rx_sh;
  logic        last_f;
  logic        accept, state_done, byte_done;
  logic        com_clk_d, cs_d, ready_d, busy_d, mosi_d;

  assign accept    = tx_valid & tx_ready;
  assign byte_done = (state == HIGH) && state_done && (bit_cnt == 3'd0);

  always_comb begin
    state_done = 1'b0;
    case (state)
      SETUP:     state_done = (cnt == SETUP_END);
      LOW, HIGH: state_done = (cnt == DIV_END);
      HOLD:      state_done = (cnt == HOLD_END);
      GAP:       state_done = (cnt == GAP_END);
      default:   state_done = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = SETUP;
      SETUP:     if (state_done) next_state = LOW;
      LOW:       if (state_done) next_state = HIGH;
      HIGH: begin
        if (state_done) begin
          if (bit_cnt != 3'd0) next_state = LOW;
          else if (last_f)     next_state = HOLD;
          else                 next_state = WAIT_NEXT;
        end
      end
      WAIT_NEXT: if (accept) next_state = LOW;
      HOLD:      if (state_done) next_state = GAP;
      GAP:       if (state_done) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the registered pins line up with the state.
  always_comb begin
    com_clk_d = (next_state != LOW);
    cs_d      = (next_state == IDLE) || (next_state == GAP);
    ready_d   = (next_state == IDLE) || (next_state == WAIT_NEXT);
    busy_d    = (next_state != IDLE);
    sh_nxt    = sh;
    if (accept)
      sh_nxt = tx_data;
    else if ((state == HIGH) && state_done)
      sh_nxt = {sh[6:0], 1'b0};
    mosi_d = MOSI;
    if ((next_state == IDLE) || (next_state == GAP) || (next_state == SETUP))
      mosi_d = 1'b0;
    else if ((next_state == LOW) && (state != LOW))
      mosi_d = sh_nxt[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      com_clk  <= 1'b1;
      CS       <= 1'b1;
      MOSI     <= 1'b0;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      state    <= next_state;
      com_clk  <= com_clk_d;
      CS       <= cs_d;
      MOSI     <= mosi_d;
      tx_ready <= ready_d;
      busy     <= busy_d;
      rx_valid <= byte_done;
      if (byte_done)
        rx_data <= rx_sh;
      if ((next_state != state) || (state == IDLE) || (state == WAIT_NEXT))
        cnt <= '0;
      else
        cnt <= cnt + 16'd1;
      if ((next_state == LOW) && ((state == SETUP) || (state == WAIT_NEXT)))
        bit_cnt <= 3'd7;
      else if ((state == HIGH) && state_done && (bit_cnt != 3'd0))
        bit_cnt <= bit_cnt - 3'd1;
    end
  end

  // MISO is captured on the same clk edge that raises com_clk.
  always_ff @(posedge clk) begin
    sh <= sh_nxt;
    if (accept)
      last_f <= tx_last;
    if ((state == LOW) && (next_state == HIGH))
      rx_sh <= {rx_sh[6:0], MISO};
  end

endmodule
